// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    // Receiver frame states, in the order a frame passes through them.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Parity modes.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per bit period (integer divide, truncating).
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Input synchroniser, bit-period counter and 3-sample majority vote.
// The counter free-runs through 0..CLKS_PER_BIT-1 while restart is low and
// is held at 0 while restart is high, so count 0 is the first cycle after
// the FSM leaves IDLE.
module uart_bit_sampler #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_serial,
    input  logic restart,
    output logic rx_s,
    output logic sample_strobe,
    output logic sample_bit,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(MID + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s0;
    logic                   s1;

    // Synchroniser chain; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Bit-period counter; wraps at the last count, never beyond it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture the first two of the three majority samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else if (!restart) begin
            if (cnt == CNT_S0) s0 <= rx_s;
            if (cnt == CNT_S1) s1 <= rx_s;
        end
    end

    // The third sample is the live line, so the vote is ready at MID+1.
    assign sample_strobe = !restart && (cnt == CNT_S2);
    assign sample_bit    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign bit_end       = !restart && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receiver: majority-voted sampling, parity, framing and
// break detection, with a single-entry valid/ready output register.
//
// Output handshake: a word transfers in any cycle where o_valid and i_ready
// are both high. o_data and all flags stay stable while o_valid is high and
// i_ready is low, except that a newly completed frame overwrites the held
// word (newest wins) and sets the sticky o_overrun, which clears on the next
// transfer. A commit in a transfer cycle keeps o_valid high.
module uart_rx_fifo_param
    import uart_pkg::*;
#(
    parameter int FPGA_clk_freq = 50000000,
    parameter int baudrate      = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_RX_Serial,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun,
    output logic                 o_busy,
    output state_t               dbg_state
);

    localparam int CLKS_PER_BIT = clks_per_bit(FPGA_clk_freq, baudrate);
    localparam int IDX_W        = $clog2(DATA_BITS + 1);

    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 8) begin : g_cpb_check
        $error("CLKS_PER_BIT must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_check
        $error("DATA_BITS must be in 5..9");
    end

    state_t               state;
    state_t               state_n;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] data_q;
    logic                 par_acc;
    logic                 par_bit;
    logic                 frame_err;

    logic rx_s;
    logic sample_strobe;
    logic sample_bit;
    logic bit_end;
    logic restart;
    logic commit;
    logic par_err_c;
    logic brk_c;

    // The counter is parked while waiting for a start edge and after commit.
    assign restart = (state == S_IDLE) || (state == S_DONE);
    assign commit  = (state == S_DONE);

    uart_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_sampler (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_serial     (i_RX_Serial),
        .restart       (restart),
        .rx_s          (rx_s),
        .sample_strobe (sample_strobe),
        .sample_bit    (sample_bit),
        .bit_end       (bit_end)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic. STOP exits at the vote of the last stop bit so a
    // start bit immediately after it is still caught from IDLE.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (!rx_s) state_n = S_START;
            S_START: begin
                if (sample_strobe && sample_bit) state_n = S_IDLE;
                else if (bit_end)                state_n = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_idx == IDX_LAST_DATA)
                    state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_end) state_n = S_STOP;
            S_STOP:   if (sample_strobe && bit_idx == IDX_LAST_STOP) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Frame datapath: data shift (LSB first), parity and stop-bit capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx   <= '0;
            data_q    <= '0;
            par_acc   <= 1'b0;
            par_bit   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bit_idx   <= '0;
                    data_q    <= '0;
                    par_acc   <= 1'b0;
                    par_bit   <= 1'b0;
                    frame_err <= 1'b0;
                end
                S_DATA: begin
                    if (sample_strobe) begin
                        data_q  <= {sample_bit, data_q[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ sample_bit;
                    end
                    if (bit_end) begin
                        bit_idx <= (bit_idx == IDX_LAST_DATA) ? '0 : bit_idx + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (sample_strobe) par_bit <= sample_bit;
                end
                S_STOP: begin
                    if (sample_strobe && !sample_bit) frame_err <= 1'b1;
                    if (bit_end) bit_idx <= bit_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Odd parity wants the total ones count (data plus parity bit) to be odd.
    assign par_err_c = (PARITY != PAR_NONE) &&
                       ((par_acc ^ par_bit) != (PARITY == PAR_ODD));
    assign brk_c     = (data_q == '0) && !par_bit && frame_err;

    // Output register and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (commit) begin
            o_valid      <= 1'b1;
            o_data       <= data_q;
            o_parity_err <= par_err_c;
            o_frame_err  <= frame_err;
            o_break      <= brk_c;
            if (o_valid && !i_ready)     o_overrun <= 1'b1;
            else if (o_valid && i_ready) o_overrun <= 1'b0;
        end else if (o_valid && i_ready) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end
    end

    assign o_busy    = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Bench for uart_rx_fifo_param: an 8N1 instance and a 7E2 instance, both at
// 20 clocks per bit, driven by directed frames. A word-level model predicts
// each accepted word; the compare process checks every transfer against it.
module tb_uart_rx_fifo_param;
    import uart_pkg::*;

    localparam int CPB = 20;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       rx_a = 1'b1, ready_a = 1'b1;
    logic       rx_b = 1'b1, ready_b = 1'b1;
    logic       valid_a, pe_a, fe_a, brk_a, ovr_a, busy_a;
    logic       valid_b, pe_b, fe_b, brk_b, ovr_b, busy_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    state_t     dbg_a, dbg_b;

    uart_rx_fifo_param #(
        .FPGA_clk_freq(50000000), .baudrate(2500000),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_RX_Serial(rx_a), .i_ready(ready_a),
        .o_valid(valid_a), .o_data(data_a), .o_parity_err(pe_a),
        .o_frame_err(fe_a), .o_break(brk_a), .o_overrun(ovr_a),
        .o_busy(busy_a), .dbg_state(dbg_a)
    );

    uart_rx_fifo_param #(
        .FPGA_clk_freq(50000000), .baudrate(2500000),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_RX_Serial(rx_b), .i_ready(ready_b),
        .o_valid(valid_b), .o_data(data_b), .o_parity_err(pe_b),
        .o_frame_err(fe_b), .o_break(brk_b), .o_overrun(ovr_b),
        .o_busy(busy_b), .dbg_state(dbg_b)
    );

    // Scoreboard state
    exp_t exp_a[$];
    exp_t exp_b[$];
    logic exp_ovr_a = 1'b0;
    logic exp_ovr_b = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word-level model: what the receiver must report for an intended frame.
    task automatic model_push(input int d, input logic [8:0] data, input logic p,
                              input logic stop_lvl);
        exp_t e;
        if (d == 0) begin
            e.data = {1'b0, data[7:0]};
            e.pe   = 1'b0;
            e.fe   = !stop_lvl;
            e.brk  = (data[7:0] == 8'h00) && !stop_lvl;
            if (!ready_a && exp_a.size() > 0) begin
                exp_a[exp_a.size()-1] = e;
                exp_ovr_a = 1'b1;
            end else begin
                exp_a.push_back(e);
            end
        end else begin
            e.data = {2'b00, data[6:0]};
            e.pe   = ((^data[6:0]) ^ p) != 1'b0;
            e.fe   = !stop_lvl;
            e.brk  = (data[6:0] == 7'h00) && !p && !stop_lvl;
            if (!ready_b && exp_b.size() > 0) begin
                exp_b[exp_b.size()-1] = e;
                exp_ovr_b = 1'b1;
            end else begin
                exp_b.push_back(e);
            end
        end
    endtask

    // Driver tasks
    task automatic drive_level(input int d, input logic lvl, input int cycles);
        if (d == 0) rx_a = lvl;
        else        rx_b = lvl;
        repeat (cycles) tick();
    endtask

    // glitch_bit >= 0 puts a one-clock low pulse inside that (high) data bit.
    task automatic send_frame(input int d, input logic [8:0] data, input logic p,
                              input logic stop_lvl, input int gap_bits,
                              input int glitch_bit, input bit push);
        int nd = (d == 0) ? 8 : 7;
        int ns = (d == 0) ? 1 : 2;
        if (push) model_push(d, data, p, stop_lvl);
        drive_level(d, 1'b0, CPB);
        for (int i = 0; i < nd; i++) begin
            if (i == glitch_bit) begin
                drive_level(d, 1'b1, 11);
                drive_level(d, 1'b0, 1);
                drive_level(d, 1'b1, CPB - 12);
            end else begin
                drive_level(d, data[i], CPB);
            end
        end
        if (d == 1) drive_level(d, p, CPB);
        for (int i = 0; i < ns; i++) drive_level(d, stop_lvl, CPB);
        drive_level(d, 1'b1, gap_bits * CPB);
    endtask

    // Compare process: every accepted word is checked against the model.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid_a && ready_a) begin
                if (exp_a.size() == 0) begin
                    check("a_unexpected_valid", 32'(valid_a), 32'd0);
                end else begin
                    e = exp_a.pop_front();
                    check("a_data",    32'(data_a), 32'(e.data));
                    check("a_par_err", 32'(pe_a),   32'(e.pe));
                    check("a_frm_err", 32'(fe_a),   32'(e.fe));
                    check("a_break",   32'(brk_a),  32'(e.brk));
                    check("a_overrun", 32'(ovr_a),  32'(exp_ovr_a));
                    exp_ovr_a = 1'b0;
                end
            end
            if (valid_b && ready_b) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected_valid", 32'(valid_b), 32'd0);
                end else begin
                    e = exp_b.pop_front();
                    check("b_data",    32'(data_b), 32'(e.data));
                    check("b_par_err", 32'(pe_b),   32'(e.pe));
                    check("b_frm_err", 32'(fe_b),   32'(e.fe));
                    check("b_break",   32'(brk_b),  32'(e.brk));
                    check("b_overrun", 32'(ovr_b),  32'(exp_ovr_b));
                    exp_ovr_b = 1'b0;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #(50000 * 10);
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d expected done", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        exp_t lit;
        int   waited;

        // Reset state
        repeat (3) tick();
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_data_a",  32'(data_a),  32'd0);
        check("rst_flags_a", 32'({pe_a, fe_a, brk_a, ovr_a, busy_a}), 32'd0);
        check("rst_valid_b", 32'(valid_b), 32'd0);
        check("rst_state_a", 32'(dbg_a),   32'(S_IDLE));
        rst_n = 1'b1;
        repeat (2 * CPB) tick();
        check("idle_busy_a", 32'(busy_a), 32'd0);

        // 8N1 0xA5, then a stop bit forced low, then a plain zero byte
        send_frame(0, 9'h0A5, 1'b0, 1'b1, 2, -1, 1'b1);
        send_frame(0, 9'h03C, 1'b0, 1'b0, 2, -1, 1'b1);
        send_frame(0, 9'h000, 1'b0, 1'b1, 2, -1, 1'b1);

        // One-clock glitch inside data bit 3 of 0xFF
        send_frame(0, 9'h0FF, 1'b0, 1'b1, 2, 3, 1'b1);

        // Short start pulse is rejected and the FSM returns to idle
        drive_level(0, 1'b0, 5);
        check("short_start_busy", 32'(busy_a), 32'd1);
        rx_a = 1'b1;
        waited = 0;
        while (busy_a && waited < CPB) begin
            tick();
            waited++;
        end
        check("short_start_idle", 32'(busy_a), 32'd0);
        drive_level(0, 1'b1, 2 * CPB);

        // Line low 12 bit times: a break frame, then the tail of the low
        // period is taken as a start bit and data bit 0 of a second frame,
        // whose remaining bits read high (0xFE, clean).
        lit = '{data: 9'h000, pe: 1'b0, fe: 1'b1, brk: 1'b1};
        exp_a.push_back(lit);
        lit = '{data: 9'h0FE, pe: 1'b0, fe: 1'b0, brk: 1'b0};
        exp_a.push_back(lit);
        drive_level(0, 1'b0, 12 * CPB);
        drive_level(0, 1'b1, 12 * CPB);

        // Overrun: two frames with the consumer stalled, newest wins
        ready_a = 1'b0;
        send_frame(0, 9'h011, 1'b0, 1'b1, 0, -1, 1'b1);
        send_frame(0, 9'h022, 1'b0, 1'b1, 1, -1, 1'b1);
        check("ovr_valid", 32'(valid_a), 32'd1);
        check("ovr_data",  32'(data_a),  32'h22);
        check("ovr_flag",  32'(ovr_a),   32'd1);
        ready_a = 1'b1;
        tick();
        check("ovr_valid_falls", 32'(valid_a), 32'd0);
        check("ovr_flag_clears", 32'(ovr_a),   32'd0);

        // 7E2: wrong parity bit held for inspection, then good parity frames
        ready_b = 1'b0;
        send_frame(1, 9'h041, 1'b1, 1'b1, 1, -1, 1'b1);
        check("b_hold_valid",  32'(valid_b), 32'd1);
        check("b_hold_data",   32'(data_b),  32'h41);
        check("b_hold_parerr", 32'(pe_b),    32'd1);
        check("b_hold_frmerr", 32'(fe_b),    32'd0);
        ready_b = 1'b1;
        tick();
        send_frame(1, 9'h041, 1'b0, 1'b1, 1, -1, 1'b1);
        send_frame(1, 9'h07F, 1'b1, 1'b1, 1, -1, 1'b1);
        send_frame(1, 9'h07F, 1'b0, 1'b1, 1, -1, 1'b1);
        send_frame(1, 9'h000, 1'b0, 1'b0, 2, -1, 1'b1);
        send_frame(1, 9'h055, 1'b0, 1'b1, 2, -1, 1'b1);

        // Reset in the middle of a frame: nothing partial is presented
        drive_level(0, 1'b0, 3 * CPB);
        check("mid_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        repeat (3) tick();
        check("mid_rst_valid", 32'(valid_a), 32'd0);
        check("mid_rst_flags", 32'({pe_a, fe_a, brk_a, ovr_a, busy_a}), 32'd0);
        check("mid_rst_data",  32'(data_a), 32'd0);
        rst_n = 1'b1;
        repeat (12 * CPB) tick();
        check("mid_after_valid", 32'(valid_a), 32'd0);
        check("mid_after_busy",  32'(busy_a),  32'd0);

        // Every predicted word must have been delivered
        check("a_missing_words", 32'(exp_a.size()), 32'd0);
        check("b_missing_words", 32'(exp_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
